// File: rtl/bzled_pkg.sv
// bzled_pkg: shared FSM encoding, pattern-table field layout and duty scaling for the buzzer/RGB sequencer.
package bzled_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_APPLY, S_PLAY, S_DONE} state_e;

    localparam int ENTRY_W = 40;
    localparam int DUR_LSB = 32;
    localparam int BZ_LSB  = 24;
    localparam int R_LSB   = 16;
    localparam int G_LSB   = 8;
    localparam int B_LSB   = 0;

    // Low 32 bits of (freq * duty8) >> 8, i.e. bits [39:8] of the 40-bit product.
    function automatic logic [31:0] scale_duty(input logic [31:0] freq, input logic [7:0] duty);
        return 32'(({8'd0, freq} * {32'd0, duty}) >> 8);
    endfunction
endpackage

// File: rtl/bzled_seq_ctrl_if.sv
// bzled_seq_ctrl_if: host registers, sequencer controls, table write port and PWM-side outputs.
interface bzled_seq_ctrl_if #(parameter int AW = 4);
    logic [31:0] HOST_FREQ, HOST_BZ, HOST_R, HOST_G, HOST_B;
    logic SEQ_START, SEQ_STOP, SEQ_LOOP, TBL_WE;
    logic [AW-1:0] TBL_ADDR;
    logic [39:0] TBL_WDATA;
    logic [31:0] FREQ_Cnt_Set, BZ_Puty_Set, LEDR_Puty_Set, LEDG_Puty_Set, LEDB_Puty_Set;
    logic SEQ_BUSY, SEQ_DONE;
    logic [AW-1:0] SEQ_STEP;

    modport master (
        output HOST_FREQ, HOST_BZ, HOST_R, HOST_G, HOST_B, SEQ_START, SEQ_STOP, SEQ_LOOP,
               TBL_WE, TBL_ADDR, TBL_WDATA,
        input  FREQ_Cnt_Set, BZ_Puty_Set, LEDR_Puty_Set, LEDG_Puty_Set, LEDB_Puty_Set,
               SEQ_BUSY, SEQ_DONE, SEQ_STEP
    );
    modport slave (
        input  HOST_FREQ, HOST_BZ, HOST_R, HOST_G, HOST_B, SEQ_START, SEQ_STOP, SEQ_LOOP,
               TBL_WE, TBL_ADDR, TBL_WDATA,
        output FREQ_Cnt_Set, BZ_Puty_Set, LEDR_Puty_Set, LEDG_Puty_Set, LEDB_Puty_Set,
               SEQ_BUSY, SEQ_DONE, SEQ_STEP
    );
endinterface

// File: rtl/bzled_seq_tbl.sv
// bzled_seq_tbl: DEPTH x 40 pattern RAM, one write port, synchronous read-first read port.
module bzled_seq_tbl
    import bzled_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge CLK) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/bzled_seq_ctrl.sv
// bzled_seq_ctrl: host passthrough or autonomous step-pattern playback in front of the buzzer/RGB PWM block.
// Define BZLED_SEQ_LOOP_EN to let SEQ_LOOP restart the pattern at step 0 instead of finishing.
module bzled_seq_ctrl
    import bzled_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 50000
) (
    input logic             CLK,
    input logic             RST_n,
    bzled_seq_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_e state_q, state_d;
    logic [AW-1:0] step_q, step_d, seq_step_q, seq_step_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [7:0] dur_q, dur_d;
    logic [31:0] freq_q, freq_d, bz_q, bz_d, r_q, r_d, g_q, g_d, b_q, b_d;
    logic [ENTRY_W-1:0] rdata;
    logic busy, tick_wrap, step_end, last_step, term, loop_en;

`ifdef BZLED_SEQ_LOOP_EN
    assign loop_en = bus.SEQ_LOOP;
`else
    logic unused_loop;
    assign unused_loop = bus.SEQ_LOOP;
    assign loop_en = 1'b0;
`endif

    bzled_seq_tbl #(.DEPTH(DEPTH)) u_tbl (
        .CLK(CLK),
        .we_i(bus.TBL_WE),
        .waddr_i(bus.TBL_ADDR),
        .wdata_i(bus.TBL_WDATA),
        .raddr_i(step_q),
        .rdata_o(rdata)
    );

    assign busy      = state_q inside {S_LOAD, S_APPLY, S_PLAY};
    assign tick_wrap = tick_q == TW'(TICK_DIV - 1);
    assign step_end  = tick_wrap && dur_q == 8'd1;
    assign last_step = step_q == AW'(DEPTH - 1);
    assign term      = rdata[DUR_LSB +: 8] == 8'd0;

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        seq_step_d = seq_step_q;
        tick_d     = '0;
        dur_d      = dur_q;
        freq_d     = freq_q;
        bz_d       = bz_q;
        r_d        = r_q;
        g_d        = g_q;
        b_d        = b_q;
        case (state_q)
            S_IDLE: begin
                freq_d = bus.HOST_FREQ;
                bz_d   = bus.HOST_BZ;
                r_d    = bus.HOST_R;
                g_d    = bus.HOST_G;
                b_d    = bus.HOST_B;
                if (bus.SEQ_START && !bus.SEQ_STOP) begin
                    state_d = S_LOAD;
                    step_d  = '0;
                end
            end
            S_LOAD: state_d = S_APPLY;
            S_APPLY: begin
                if (term) begin
                    state_d = loop_en ? S_LOAD : S_DONE;
                    step_d  = '0;
                end else begin
                    freq_d     = bus.HOST_FREQ;
                    bz_d       = scale_duty(bus.HOST_FREQ, rdata[BZ_LSB +: 8]);
                    r_d        = scale_duty(bus.HOST_FREQ, rdata[R_LSB +: 8]);
                    g_d        = scale_duty(bus.HOST_FREQ, rdata[G_LSB +: 8]);
                    b_d        = scale_duty(bus.HOST_FREQ, rdata[B_LSB +: 8]);
                    seq_step_d = step_q;
                    dur_d      = rdata[DUR_LSB +: 8];
                    state_d    = S_PLAY;
                end
            end
            S_PLAY: begin
                tick_d = tick_wrap ? '0 : tick_q + 1'b1;
                dur_d  = tick_wrap ? dur_q - 8'd1 : dur_q;
                // The last entry behaves as if a terminator followed it; the index wraps to 0 when looping.
                if (step_end) begin
                    step_d  = step_q + 1'b1;
                    state_d = (last_step && !loop_en) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.SEQ_STOP && busy) state_d = S_IDLE;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            seq_step_q <= '0;
            tick_q     <= '0;
            dur_q      <= '0;
            freq_q     <= '0;
            bz_q       <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            seq_step_q <= seq_step_d;
            tick_q     <= tick_d;
            dur_q      <= dur_d;
            freq_q     <= freq_d;
            bz_q       <= bz_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

    assign bus.FREQ_Cnt_Set  = freq_q;
    assign bus.BZ_Puty_Set   = bz_q;
    assign bus.LEDR_Puty_Set = r_q;
    assign bus.LEDG_Puty_Set = g_q;
    assign bus.LEDB_Puty_Set = b_q;
    assign bus.SEQ_BUSY      = busy;
    assign bus.SEQ_DONE      = state_q == S_DONE;
    assign bus.SEQ_STEP      = seq_step_q;
endmodule

// File: tb/tb_bzled_seq_ctrl.sv
// tb_bzled_seq_ctrl: randomized bench for bzled_seq_ctrl with a pattern-level reference model and a
// tagged scoreboard queue drained by a negedge monitor.
module tb_bzled_seq_ctrl;
    localparam int DEPTH = 16;
    localparam int TICK  = 4;

    typedef struct packed {
        logic [31:0] tag, freq, bz, r, g, b;
        logic busy, done;
        logic [3:0] step;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_n = 1'b1;
    int cyc = 0, n_vec = 0, n_err = 0, tidx = 0;
    exp_t exp_q[$], tr[$];
    logic [39:0] tbl_m [DEPTH];
    logic [3:0] last_step = '0;

    bzled_seq_ctrl_if #(.AW(4)) bus();
    bzled_seq_ctrl #(.DEPTH(DEPTH), .TICK_DIV(TICK)) dut (.CLK(CLK), .RST_n(RST_n), .bus(bus));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, want);
        end
    endtask

    task automatic check_out(input exp_t e);
        chk("freq", bus.FREQ_Cnt_Set, e.freq);
        chk("bz", bus.BZ_Puty_Set, e.bz);
        chk("ledr", bus.LEDR_Puty_Set, e.r);
        chk("ledg", bus.LEDG_Puty_Set, e.g);
        chk("ledb", bus.LEDB_Puty_Set, e.b);
        chk("busy", 32'(bus.SEQ_BUSY), 32'(e.busy));
        chk("done", 32'(bus.SEQ_DONE), 32'(e.done));
        chk("step", 32'(bus.SEQ_STEP), 32'(e.step));
    endtask

    always @(negedge CLK) begin : mon
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].tag < 32'(cyc)) begin
            n_err++;
            $display("FAIL missed at cycle %0d: got no check, expected tag %0d", cyc, exp_q[0].tag);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].tag == 32'(cyc)) begin
            e = exp_q.pop_front();
            check_out(e);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    function automatic logic [31:0] sc(input logic [31:0] f, input logic [7:0] d);
        return 32'((64'(f) * 64'(d)) / 64'd256);
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e = '0;
        e.freq = bus.HOST_FREQ;
        e.bz = bus.HOST_BZ;
        e.r = bus.HOST_R;
        e.g = bus.HOST_G;
        e.b = bus.HOST_B;
        e.step = last_step;
        return e;
    endfunction

    // Expected outputs after each edge from the START edge on: two host cycles, each step held
    // DUR*TICK+2 cycles, then a DONE cycle and one held IDLE cycle.
    function automatic void build();
        exp_t e;
        logic [7:0] d;
        tr.delete();
        tidx = DEPTH;
        e = idle_exp();
        e.busy = 1'b1;
        tr.push_back(e);
        tr.push_back(e);
        for (int s = 0; s < DEPTH; s++) begin
            d = tbl_m[s][39:32];
            if (d == 8'd0) begin
                tidx = s;
                e.busy = 1'b0;
                e.done = 1'b1;
                tr.push_back(e);
                break;
            end
            e.freq = bus.HOST_FREQ;
            e.bz = sc(bus.HOST_FREQ, tbl_m[s][31:24]);
            e.r = sc(bus.HOST_FREQ, tbl_m[s][23:16]);
            e.g = sc(bus.HOST_FREQ, tbl_m[s][15:8]);
            e.b = sc(bus.HOST_FREQ, tbl_m[s][7:0]);
            e.step = 4'(s);
            e.busy = 1'b1;
            repeat (int'(d) * TICK) tr.push_back(e);
            if (s == DEPTH - 1) begin
                e.busy = 1'b0;
                e.done = 1'b1;
                tr.push_back(e);
            end else repeat (2) tr.push_back(e);
        end
        e.busy = 1'b0;
        e.done = 1'b0;
        tr.push_back(e);
    endfunction

    task automatic push(input exp_t e);
        e.tag = 32'(cyc + 1);
        exp_q.push_back(e);
        @(posedge CLK);
        #2;
    endtask

    task automatic clr();
        bus.SEQ_START = 1'b0;
        bus.SEQ_STOP = 1'b0;
        bus.TBL_WE = 1'b0;
    endtask

    task automatic set_host(input logic [31:0] f, bz, r, g, b);
        bus.HOST_FREQ = f;
        bus.HOST_BZ = bz;
        bus.HOST_R = r;
        bus.HOST_G = g;
        bus.HOST_B = b;
    endtask

    task automatic rand_host();
        set_host($urandom, $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic check_zero();
        exp_t z;
        z = '0;
        check_out(z);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if ($urandom_range(3) == 0) rand_host();
            clr();
            bus.SEQ_STOP = ($urandom_range(3) == 0);
`ifndef BZLED_SEQ_LOOP_EN
            bus.SEQ_LOOP = 1'($urandom_range(1));
`endif
            push(idle_exp());
        end
        clr();
    endtask

    task automatic wr(input logic [3:0] a, input logic [39:0] d);
        clr();
        bus.TBL_WE = 1'b1;
        bus.TBL_ADDR = a;
        bus.TBL_WDATA = d;
        tbl_m[a] = d;
        push(idle_exp());
        clr();
    endtask

    task automatic async_reset();
        clr();
        RST_n = 1'b0;
        #1;
        check_zero();
        exp_q.delete();
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RST_n = 1'b1;
        last_step = '0;
    endtask

    function automatic logic [39:0] rand_entry();
        logic [7:0] d;
        d = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
        return {d, 32'($urandom)};
    endfunction

    task automatic play(input bit new_host, input int stop_k, input int rst_k);
        exp_t e;
        bit busy_before;
        logic [3:0] a;
        if (new_host) rand_host();
        build();
        for (int k = 0; k < tr.size(); k++) begin
            busy_before = (k > 0) && tr[k-1].busy;
            if (k == rst_k && busy_before) begin
                async_reset();
                return;
            end
            bus.SEQ_START = (k == 0) || (busy_before && $urandom_range(7) == 0);
            bus.SEQ_STOP = (k == stop_k);
            bus.TBL_WE = 1'b0;
            // Writes land only beyond the terminator, so they shape later patterns, not this one.
            if (busy_before && tidx < DEPTH - 1 && $urandom_range(5) == 0) begin
                a = 4'($urandom_range(tidx + 1, DEPTH - 1));
                bus.TBL_WE = 1'b1;
                bus.TBL_ADDR = a;
                bus.TBL_WDATA = rand_entry();
                tbl_m[a] = bus.TBL_WDATA;
            end
            e = tr[k];
            if (k == stop_k && (k == 0 || busy_before)) begin
                if (k == 0) e = idle_exp();
                e.busy = 1'b0;
                e.done = 1'b0;
                last_step = e.step;
                push(e);
                clr();
                return;
            end
            push(e);
        end
        last_step = tr[tr.size()-1].step;
        clr();
    endtask

    initial begin
        clr();
        set_host(0, 0, 0, 0, 0);
        bus.SEQ_LOOP = 1'b0;
        bus.TBL_ADDR = '0;
        bus.TBL_WDATA = '0;
        #1 RST_n = 1'b0;
        #2 check_zero();
        @(posedge CLK);
        @(posedge CLK);
        #2 RST_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) wr(4'(i), rand_entry());
        set_host(1000, 0, 300, 0, 0);
        push(idle_exp());
        wr(0, {8'd2, 8'd128, 8'd255, 8'd0, 8'd0});
        wr(1, {8'd1, 8'd0, 8'd0, 8'd64, 8'd0});
        wr(2, 40'd0);
        set_host(1000, 7, 8, 9, 10);
        push(idle_exp());
        play(1'b0, -1, -1);
        idle(3);
        play(1'b0, 0, -1);
        idle(2);
        play(1'b0, 5, -1);
        idle(2);
        for (int i = 0; i < DEPTH; i++) wr(4'(i), {8'd1, 32'($urandom)});
        play(1'b1, -1, -1);
        idle(2);
        play(1'b1, -1, 6);
        idle(3);
        wr(0, 40'd0);
        play(1'b1, -1, -1);
        idle(2);
        repeat (30) begin
            repeat ($urandom_range(4)) wr(4'($urandom_range(DEPTH - 1)), rand_entry());
            idle($urandom_range(3));
            play(1'b1, ($urandom_range(3) == 0) ? int'($urandom_range(40)) : -1,
                 ($urandom_range(9) == 0) ? int'($urandom_range(30)) : -1);
        end
        idle(3);
        @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
